// File: rtl/network_run_ctrl.sv
// network_run_ctrl: issues one network step per beat of a host run command,
// gates each network output vector to the sink, tags the final beat of the run
// and pulses done when the run completes.
module network_run_ctrl #(
    parameter int unsigned NET_NUM_OUT = 8,
    parameter int unsigned RUN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [RUN_WIDTH-1:0]   cmd_cycles,
    input  logic                   abort,
    output logic                   net_step,
    input  logic                   net_valid,
    output logic                   net_ready,
    input  logic [NET_NUM_OUT-1:0] net_out,
    output logic                   snk_valid,
    input  logic                   snk_ready,
    output logic [NET_NUM_OUT-1:0] snk,
    output logic                   snk_last,
    output logic                   done,
    output logic [RUN_WIDTH-1:0]   run_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        COLLECT = 2'd2
    } state_t;

    state_t               state;
    logic [RUN_WIDTH-1:0] remaining;
    logic [RUN_WIDTH-1:0] run_count_q;
    logic                 done_q;

    logic in_collect;
    logic handshake;
    logic final_beat;

    // Collect-phase qualifiers; reset forces every handshake output low.
    assign in_collect = (state == COLLECT) && !rst;
    assign handshake  = in_collect && net_valid && snk_ready;
    // An abort arriving on the handshake cycle itself also ends the run on that beat.
    assign final_beat = (remaining == '0) || abort;

    // Run sequencer: command acceptance, step issue, beat collection and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            run_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        remaining   <= cmd_cycles;
                        run_count_q <= '0;
                        if (cmd_cycles == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                STEP: begin
                    // Entered only with remaining >= 1, so the decrement cannot wrap.
                    remaining <= abort ? '0 : remaining - RUN_WIDTH'(1);
                    state     <= COLLECT;
                end
                COLLECT: begin
                    if (abort) begin
                        remaining <= '0;
                    end
                    if (handshake) begin
                        run_count_q <= run_count_q + RUN_WIDTH'(1);
                        if (final_beat) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode; the net-to-sink path is a pure passthrough while collecting.
    assign cmd_ready = (state == IDLE) && !rst;
    assign net_step  = (state == STEP) && !rst;
    assign net_ready = in_collect && snk_ready;
    assign snk_valid = in_collect && net_valid;
    assign snk       = in_collect ? net_out : '0;
    assign snk_last  = in_collect && final_beat;
    assign done      = done_q && !rst;
    assign run_count = rst ? '0 : run_count_q;

endmodule

// File: doc/network_run_ctrl.md
# network_run_ctrl

Run-sequencing controller between the host command path and the network output stream. It accepts a run command holding a time-step count and pulses the network once per step. It gates each resulting output vector through to the sink with valid/ready, tags the final vector of the run, and signals completion. It replaces the direct network-to-sink passthrough when the host must bound how many network steps execute per command.

## Interface
Parameters:
- NET_NUM_OUT, 8, width of the network output vector and of `snk`
- RUN_WIDTH, 16, width of the step count; the maximum run is 2^RUN_WIDTH-1 steps

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  run command offered
- cmd_ready  out  1  controller accepts a command
- cmd_cycles  in  RUN_WIDTH  number of network steps to run
- abort  in  1  end the current run after the beat in flight
- net_step  out  1  one-cycle pulse that advances the network one time step
- net_valid  in  1  network output vector available
- net_ready  out  1  controller consumes the network output
- net_out  in  NET_NUM_OUT  network output vector
- snk_valid  out  1  sink beat offered
- snk_ready  in  1  sink accepts the beat
- snk  out  NET_NUM_OUT  sink data, equal to net_out
- snk_last  out  1  beat is the final step of the run
- done  out  1  one-cycle pulse when a run completes
- run_count  out  RUN_WIDTH  beats delivered in the current or most recent run

## Operation
- Registers:
  - state ∈ {IDLE, STEP, COLLECT}
  - remaining (RUN_WIDTH)
  - run_count (RUN_WIDTH)
  - done (1)
- IDLE:
  - cmd_ready=1; all other handshake outputs are 0.
  - On cmd_valid, load remaining=cmd_cycles and clear run_count.
  - If cmd_cycles≠0, go to STEP. If cmd_cycles=0, stay in IDLE and set done for the next cycle; no sink beat is produced.
- STEP:
  - net_step=1 for exactly this cycle; remaining decrements by 1.
  - Unconditionally go to COLLECT.
- COLLECT:
  - Combinational gating: net_ready=snk_ready, snk_valid=net_valid, snk=net_out.
  - snk_last=1 when remaining=0.
  - On handshake (net_valid & snk_ready), run_count increments. If remaining=0, go to IDLE and set done; otherwise go to STEP.
- Outside COLLECT: net_ready=0, snk_valid=0, snk_last=0, and snk is don't-care (drive 0). Network output arriving early is held off, never dropped.
- abort:
  - Sampled in STEP or COLLECT only; ignored in IDLE.
  - It forces remaining to 0, so the beat of the current or just-issued step carries snk_last=1 and ends the run.
  - An issued net_step is never left uncollected.
- cmd_ready=0 whenever state≠IDLE, so no command queueing occurs.
- Arithmetic:
  - remaining never underflows, because it decrements only in STEP, which is entered only with remaining≥1.
  - run_count never exceeds cmd_cycles and needs no saturation.

## Timing
- Reset (rst high at an edge) gives state=IDLE, remaining=0, run_count=0, done=0.
- While rst is high, every output is 0, including cmd_ready.
- From the first cycle after rst falls, cmd_ready=1.
- With the command accepted at edge T:
  - net_step is high in cycle T+1.
  - COLLECT begins at T+2.
  - The earliest sink handshake is at the T+2 edge if net_valid and snk_ready are already high.
- Minimum pacing is 2 cycles per step. An N-step run with no backpressure completes its last handshake at edge T+2N. done is high in cycle T+2N+1, and cmd_ready is high in that same cycle.
- Zero-step command accepted at edge T: done=1 in T+1 with cmd_ready=1. A back-to-back command is accepted in T+1.
- done is high for exactly one cycle per accepted command.
- snk_valid may deassert only as net_valid does; the controller adds no bubble or combinational loop beyond the net→snk passthrough.
- Reset mid-run: the run is discarded immediately. No done pulse occurs, and run_count returns to 0.
- abort together with the final handshake: the run ends normally, with done exactly once.

## Test plan
- Reset, then cmd_cycles=3 with net_valid=snk_ready=1 held high → net_step high in cycles 1, 3 and 5 after acceptance. Three beats are delivered, and only the third has snk_last=1. done is high 7 cycles after acceptance, and run_count=3.
- cmd_cycles=0 → no net_step and no snk_valid. done is high the next cycle, and a second command is accepted in that same cycle.
- cmd_cycles=2 with snk_ready low for 5 cycles during the first COLLECT → net_ready stays 0 and net_out is stable at the sink. The next net_step is issued only after the handshake completes.
- cmd_cycles=10 with abort pulsed during the 4th STEP → the 4th beat has snk_last=1, there are no further net_step pulses, done pulses once, and run_count=4.
- rst asserted during the COLLECT phase of a 5-step run → all outputs are 0 while rst is high. Afterwards the state is IDLE with run_count=0, no done pulse, and a new command is accepted.
- cmd_cycles=2^RUN_WIDTH-1 (RUN_WIDTH=4, so 15 steps) → exactly 15 beats, with snk_last on the 15th only and run_count=15.
